// File: rtl/count_pkg.sv
// Shared constants for the cascaded modulo counter.
// Direction and limit-mode encodings used across the chain.
package count_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

endpackage

// File: rtl/count_digit.sv
// One modulo-MODULO digit of the counter chain.
// Steps up/down with wrap; clear, clamped load and limit hold.
module count_digit
  import count_pkg::*;
#(
  parameter  int MODULO = 10,
  localparam int N      = $clog2(MODULO)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         up,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         hold,
  output logic [N-1:0] value,
  output logic         tc
);

  localparam logic [N-1:0] MAX = N'(MODULO - 1);

  logic [N-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clear) begin
      val_d = '0;
    end else if (load) begin
      val_d = (load_value > MAX) ? MAX : load_value;
    end else if (step && !hold) begin
      if (up == CNT_UP) begin
        val_d = (val_q == MAX) ? '0 : val_q + N'(1);
      end else begin
        val_d = (val_q == '0) ? MAX : val_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign value = val_q;
  assign tc    = (up == CNT_UP) ? (val_q == MAX)
                                : (val_q == '0);

endmodule

// File: rtl/count_chain.sv
// Cascaded up/down modulo counter (default 4-digit BCD).
// Ripple-free carry enables, terminal flags, registered OVF pulse.
module count_chain
  import count_pkg::*;
#(
  parameter  int MODULO = 10,
  parameter  int DIGITS = 4,
  localparam int N      = $clog2(MODULO)
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                ENABLE,
  input  logic                UP_DOWN,
  input  logic                CLEAR,
  input  logic                LOAD,
  input  logic [DIGITS*N-1:0] LOAD_VALUE,
  input  logic                SAT_MODE,
  output logic [DIGITS*N-1:0] COUNT,
  output logic [DIGITS-1:0]   TC_DIGIT,
  output logic                TC,
  output logic                OVF
);

  logic [DIGITS-1:0] carry;
  logic              limit;
  logic              hold;
  logic              ovf_q, ovf_d;

  assign carry[0] = ENABLE;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    count_digit #(
      .MODULO(MODULO)
    ) u_digit (
      .clk       (CLK),
      .rst_n     (RSTn),
      .step      (carry[i]),
      .up        (UP_DOWN),
      .clear     (CLEAR),
      .load      (LOAD),
      .load_value(LOAD_VALUE[i*N +: N]),
      .hold      (hold),
      .value     (COUNT[i*N +: N]),
      .tc        (TC_DIGIT[i])
    );
    if (i < DIGITS - 1) begin : g_carry
      assign carry[i+1] = carry[i] & TC_DIGIT[i];
    end
  end

  assign TC    = &TC_DIGIT;
  assign limit = ENABLE & TC & ~CLEAR & ~LOAD;
  // In saturate mode every digit freezes at the limit instead of wrapping.
  assign hold  = limit & (SAT_MODE == CNT_SAT);
  assign ovf_d = limit;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;

endmodule

// File: tb/tb_count_chain.sv
// Directed bench for count_chain, MODULO=10 DIGITS=4 (BCD).
// Per-scenario tasks with inline expected-value checks.
module tb_count_chain;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        ENABLE;
  logic        UP_DOWN;
  logic        CLEAR;
  logic        LOAD;
  logic [15:0] LOAD_VALUE;
  logic        SAT_MODE;
  logic [15:0] COUNT;
  logic [3:0]  TC_DIGIT;
  logic        TC;
  logic        OVF;

  int n_checks = 0;
  int n_fail   = 0;

  count_chain #(
    .MODULO(10),
    .DIGITS(4)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .ENABLE    (ENABLE),
    .UP_DOWN   (UP_DOWN),
    .CLEAR     (CLEAR),
    .LOAD      (LOAD),
    .LOAD_VALUE(LOAD_VALUE),
    .SAT_MODE  (SAT_MODE),
    .COUNT     (COUNT),
    .TC_DIGIT  (TC_DIGIT),
    .TC        (TC),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_val(input logic [15:0] v);
    LOAD = 1'b1;
    LOAD_VALUE = v;
    tick();
    LOAD = 1'b0;
  endtask

  task automatic chk_cnt(input string nm, input logic [15:0] exp_c,
                         input logic exp_o);
    n_checks++;
    if (COUNT !== exp_c || OVF !== exp_o) begin
      n_fail++;
      $display("FAIL %s: COUNT=%h OVF=%b, expected COUNT=%h OVF=%b",
               nm, COUNT, OVF, exp_c, exp_o);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    ENABLE = 1'b0; UP_DOWN = 1'b0; CLEAR = 1'b0; LOAD = 1'b0;
    LOAD_VALUE = '0; SAT_MODE = 1'b0;
    #2;
    n_checks++;
    if (COUNT !== 16'h0000 || OVF !== 1'b0 || TC !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init: COUNT=%h OVF=%b TC=%b, expected 0000 0 1",
               COUNT, OVF, TC);
    end
    tick();
    RSTn = 1'b1;
    tick();
    load_val(16'h0536);
    UP_DOWN = 1'b1;
    ENABLE = 1'b1;
    tick();
    chk_cnt("reset_precount", 16'h0537, 1'b0);
    #2;
    RSTn = 1'b0;
    #1;
    chk_cnt("reset_async", 16'h0000, 1'b0);
    #1;
    RSTn = 1'b1;
    tick();
    chk_cnt("reset_resume", 16'h0001, 1'b0);
    ENABLE = 1'b0;
  endtask

  task automatic test_up();
    SAT_MODE = 1'b0;
    UP_DOWN = 1'b1;
    load_val(16'h0099);
    ENABLE = 1'b1;
    tick();
    chk_cnt("up_0099", 16'h0100, 1'b0);
    n_checks++;
    if (TC_DIGIT !== 4'b0000) begin
      n_fail++;
      $display("FAIL up_tcdigit: TC_DIGIT=%b expected 0000", TC_DIGIT);
    end
    ENABLE = 1'b0;
    load_val(16'h9999);
    ENABLE = 1'b1;
    tick();
    chk_cnt("up_wrap", 16'h0000, 1'b1);
    tick();
    chk_cnt("up_wrap_next", 16'h0001, 1'b0);
    ENABLE = 1'b0;
  endtask

  task automatic test_down();
    SAT_MODE = 1'b0;
    UP_DOWN = 1'b0;
    load_val(16'h0100);
    ENABLE = 1'b1;
    tick();
    chk_cnt("down_0100", 16'h0099, 1'b0);
    ENABLE = 1'b0;
    load_val(16'h1000);
    ENABLE = 1'b1;
    tick();
    chk_cnt("down_1000", 16'h0999, 1'b0);
    ENABLE = 1'b0;
    load_val(16'h0000);
    n_checks++;
    if (TC !== 1'b1 || TC_DIGIT !== 4'b1111) begin
      n_fail++;
      $display("FAIL down_tc: TC=%b TC_DIGIT=%b, expected 1 1111",
               TC, TC_DIGIT);
    end
    ENABLE = 1'b1;
    tick();
    chk_cnt("down_wrap", 16'h9999, 1'b1);
    tick();
    chk_cnt("down_wrap_next", 16'h9998, 1'b0);
    ENABLE = 1'b0;
  endtask

  task automatic test_sat();
    SAT_MODE = 1'b1;
    UP_DOWN = 1'b1;
    load_val(16'h9999);
    ENABLE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cnt($sformatf("sat_hold%0d", k), 16'h9999, 1'b1);
    end
    ENABLE = 1'b0;
    tick();
    chk_cnt("sat_release", 16'h9999, 1'b0);
    SAT_MODE = 1'b0;
  endtask

  task automatic test_load_clear();
    UP_DOWN = 1'b1;
    load_val(16'h3F2C);
    chk_cnt("load_clamp", 16'h3929, 1'b0);
    CLEAR = 1'b1;
    LOAD = 1'b1;
    LOAD_VALUE = 16'h1234;
    ENABLE = 1'b1;
    tick();
    CLEAR = 1'b0;
    LOAD = 1'b0;
    ENABLE = 1'b0;
    chk_cnt("clear_load_en", 16'h0000, 1'b0);
    load_val(16'h9999);
    CLEAR = 1'b1;
    ENABLE = 1'b1;
    tick();
    CLEAR = 1'b0;
    ENABLE = 1'b0;
    chk_cnt("clear_at_limit", 16'h0000, 1'b0);
  endtask

  task automatic test_flip();
    load_val(16'h0010);
    ENABLE = 1'b1;
    UP_DOWN = 1'b0;
    tick();
    chk_cnt("flip_down", 16'h0009, 1'b0);
    UP_DOWN = 1'b1;
    tick();
    chk_cnt("flip_up", 16'h0010, 1'b0);
    ENABLE = 1'b0;
    load_val(16'h0000);
    UP_DOWN = 1'b1;
    #1;
    n_checks++;
    if (TC !== 1'b0) begin
      n_fail++;
      $display("FAIL tc_0000_up: TC=%b expected 0", TC);
    end
    UP_DOWN = 1'b0;
    #1;
    n_checks++;
    if (TC !== 1'b1) begin
      n_fail++;
      $display("FAIL tc_0000_down: TC=%b expected 1", TC);
    end
    load_val(16'h9999);
    UP_DOWN = 1'b1;
    #1;
    n_checks++;
    if (TC !== 1'b1 || TC_DIGIT !== 4'b1111) begin
      n_fail++;
      $display("FAIL tc_9999_up: TC=%b TC_DIGIT=%b expected 1 1111",
               TC, TC_DIGIT);
    end
    UP_DOWN = 1'b0;
    #1;
    n_checks++;
    if (TC !== 1'b0 || TC_DIGIT !== 4'b0000) begin
      n_fail++;
      $display("FAIL tc_9999_down: TC=%b TC_DIGIT=%b expected 0 0000",
               TC, TC_DIGIT);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_sat();
    test_load_clear();
    test_flip();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
